// File: rtl/sum_stage_pkg.sv
// sum_stage shared types and parameters.
// Stage config, control words and the saturating clamp helper.
package sum_stage_pkg;

    localparam int PEROW   = 3;
    localparam int PSUMDWD = 16;
    localparam int ASUMDWD = 12;
    localparam int SHWD    = 3;
    localparam int PPCTLWD = 8;
    localparam int ACCWD   = PSUMDWD + 2;

    typedef logic [PPCTLWD-1:0] ppctl_t;

    typedef struct packed {
        logic            first;
        logic            last;
        logic            sat_en;
        logic [SHWD-1:0] shift;
    } ssctl_t;

    typedef struct packed {
        ssctl_t ssctl;
        ppctl_t ssppctl;
    } ms_pipe_t;

    typedef struct packed {
        logic [PSUMDWD-1:0] psum;
        logic [ASUMDWD-1:0] sum;
    } ms_out_t;

    typedef struct packed {
        logic [PSUMDWD-1:0] psum;
    } ss_out_t;

    typedef enum logic {
        S_IDLE,
        S_ACC
    } grp_state_e;

    // Narrow the wide accumulator to PSUMDWD, clamping when asked.
    function automatic logic [PSUMDWD-1:0] clamp(
        input logic [ACCWD-1:0] v,
        input logic             sat
    );
        logic hi_all1;
        logic hi_any1;
        hi_all1 = &v[ACCWD-1:PSUMDWD-1];
        hi_any1 = |v[ACCWD-1:PSUMDWD-1];
        if (!sat || hi_all1 || !hi_any1) begin
            return v[PSUMDWD-1:0];
        end
        if (v[ACCWD-1]) begin
            return {1'b1, {(PSUMDWD-1){1'b0}}};
        end
        return {1'b0, {(PSUMDWD-1){1'b1}}};
    endfunction

endpackage

// File: rtl/sum_stage_if.sv
// sum_stage handshake bundle.
// Upstream beat from the multiply stage and downstream result.
interface sum_stage_if
    import sum_stage_pkg::*;
    ;

    ms_pipe_t                i_pipe;
    logic                    MS_rdy;
    logic                    MS_ack;
    ms_out_t [PEROW-1:0]     i_data;
    logic                    SS_rdy;
    logic                    SS_ack;
    ss_out_t [PEROW-1:0]     o_data;
    ppctl_t                  o_ppctl;
    logic                    o_err;

    modport master (
        output i_pipe, MS_rdy, i_data, SS_ack,
        input  MS_ack, SS_rdy, o_data, o_ppctl, o_err
    );

    modport slave (
        input  i_pipe, MS_rdy, i_data, SS_ack,
        output MS_ack, SS_rdy, o_data, o_ppctl, o_err
    );

endinterface

// File: rtl/sum_stage_sat_acc.sv
// sum_stage single-row shift-accumulate with optional saturation.
// Holds the running group sum and the emitted row result.
module sum_stage_sat_acc
    import sum_stage_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               beat_i,
    input  ssctl_t             ctl_i,
    input  logic [PSUMDWD-1:0] psum_i,
    input  logic [ASUMDWD-1:0] sum_i,
    output logic [PSUMDWD-1:0] psum_o
);

    logic [ACCWD-1:0]   acc_q;
    logic [ACCWD-1:0]   acc_d;
    logic [ACCWD-1:0]   addend;
    logic [ACCWD-1:0]   base;
    logic [ACCWD-1:0]   result;
    logic [PSUMDWD-1:0] out_q;
    logic [PSUMDWD-1:0] out_d;

    // Weighted addend, new group sum and next accumulator/result.
    always_comb begin
        addend = {{(ACCWD-ASUMDWD){sum_i[ASUMDWD-1]}}, sum_i}
                 << ctl_i.shift;
        base   = ctl_i.first
                 ? {{(ACCWD-PSUMDWD){psum_i[PSUMDWD-1]}}, psum_i}
                 : acc_q;
        result = base + addend;
        acc_d  = acc_q;
        out_d  = out_q;
        if (beat_i) begin
            acc_d = ctl_i.last ? '0 : result;
            if (ctl_i.last) begin
                out_d = clamp(result, ctl_i.sat_en);
            end
        end
    end

    // Accumulator and result registers, written only on accepted beats.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else if (beat_i) begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign psum_o = out_q;

endmodule

// File: rtl/sum_stage.sv
// sum_stage: shift-weighted group accumulation per PE row.
// Group FSM, handshake and sticky protocol error live here.
module sum_stage
    import sum_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    sum_stage_if.slave  bus
);

    grp_state_e         state_q;
    grp_state_e         state_d;
    logic               ss_rdy_q;
    logic               ss_rdy_d;
    ppctl_t             ppctl_q;
    ppctl_t             ppctl_d;
    logic               err_q;
    logic               err_d;
    logic               beat;
    logic               take;
    logic               en;
    logic [PSUMDWD-1:0] row_psum [PEROW];

    ssctl_t ctl;
    assign ctl = bus.i_pipe.ssctl;

    // Last beats wait only while an unconsumed result is held.
    assign beat = bus.MS_rdy
                  && (!ctl.last || !ss_rdy_q || bus.SS_ack);
    assign take = ss_rdy_q && bus.SS_ack;
    assign en   = beat || take;

    // Group tracking, error flag and result-valid next state.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        ss_rdy_d = ss_rdy_q;
        ppctl_d  = ppctl_q;
        if (beat) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!ctl.first) begin
                        err_d = 1'b1;
                    end
                    if (ctl.first && !ctl.last) begin
                        state_d = S_ACC;
                    end
                end
                S_ACC: begin
                    if (ctl.first) begin
                        err_d = 1'b1;
                    end
                    if (ctl.last) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (beat && ctl.last) begin
            ss_rdy_d = 1'b1;
            ppctl_d  = bus.i_pipe.ssppctl;
        end else if (take) begin
            ss_rdy_d = 1'b0;
        end
    end

    // Control registers, gated by the combined handshake enable.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            err_q    <= 1'b0;
            ss_rdy_q <= 1'b0;
            ppctl_q  <= '0;
        end else if (en) begin
            state_q  <= state_d;
            err_q    <= err_d;
            ss_rdy_q <= ss_rdy_d;
            ppctl_q  <= ppctl_d;
        end
    end

    for (genvar g = 0; g < PEROW; g++) begin : g_row
        sum_stage_sat_acc u_acc (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .beat_i (beat),
            .ctl_i  (ctl),
            .psum_i (bus.i_data[g].psum),
            .sum_i  (bus.i_data[g].sum),
            .psum_o (row_psum[g])
        );
    end

    // Pack the per-row results onto the output bundle.
    always_comb begin
        bus.o_data = '0;
        for (int r = 0; r < PEROW; r++) begin
            bus.o_data[r].psum = row_psum[r];
        end
    end

    assign bus.MS_ack  = beat;
    assign bus.SS_rdy  = ss_rdy_q;
    assign bus.o_ppctl = ppctl_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_sum_stage.sv
// Directed bench for sum_stage.
// Hand-computed vectors with immediate assertions.
module tb_sum_stage;
    import sum_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sum_stage_if bus ();

    sum_stage dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string             tag,
        input logic signed [31:0] obs,
        input logic signed [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] od(input int r);
        return $signed(bus.o_data[r].psum);
    endfunction

    task automatic drv(
        input logic       v,
        input logic       f,
        input logic       l,
        input logic       sat,
        input logic [2:0] sh,
        input logic [7:0] pp,
        input int p0, input int s0,
        input int p1, input int s1,
        input int p2, input int s2
    );
        bus.MS_rdy              = v;
        bus.i_pipe.ssctl.first  = f;
        bus.i_pipe.ssctl.last   = l;
        bus.i_pipe.ssctl.sat_en = sat;
        bus.i_pipe.ssctl.shift  = sh;
        bus.i_pipe.ssppctl      = pp;
        bus.i_data[0].psum      = 16'(p0);
        bus.i_data[0].sum       = 12'(s0);
        bus.i_data[1].psum      = 16'(p1);
        bus.i_data[1].sum       = 12'(s1);
        bus.i_data[2].psum      = 16'(p2);
        bus.i_data[2].sum       = 12'(s2);
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.SS_ack = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_ss_rdy", bus.SS_rdy, 0);
        chk("rst_data0", od(0), 0);
        chk("rst_ppctl", bus.o_ppctl, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_ms_ack", bus.MS_ack, 0);
        rst_n = 1'b1;
        tick();

        // single-beat group, held until acked
        drv(1, 1, 1, 0, 2, 8'hA5, 100, 5, -50, 3, 0, -1);
        chk("sb_ms_ack", bus.MS_ack, 1);
        tick();
        idle();
        chk("sb_rdy", bus.SS_rdy, 1);
        chk("sb_row0", od(0), 120);
        chk("sb_row1", od(1), -38);
        chk("sb_row2", od(2), -4);
        chk("sb_ppctl", bus.o_ppctl, 8'hA5);
        tick();
        chk("sb_hold_rdy", bus.SS_rdy, 1);
        chk("sb_hold_row0", od(0), 120);
        bus.SS_ack = 1'b1;
        tick();
        chk("sb_ack_rdy", bus.SS_rdy, 0);
        bus.SS_ack = 1'b0;

        // three-beat group
        drv(1, 1, 0, 0, 0, 8'h11, 0, 1, 10, -1, 0, 0);
        tick();
        chk("g3_b1_rdy", bus.SS_rdy, 0);
        drv(1, 0, 0, 0, 1, 8'h22, 0, 2, 0, -1, 0, 0);
        tick();
        chk("g3_b2_rdy", bus.SS_rdy, 0);
        drv(1, 0, 1, 0, 2, 8'h3C, 0, 3, 0, -1, 0, 0);
        tick();
        idle();
        chk("g3_rdy", bus.SS_rdy, 1);
        chk("g3_row0", od(0), 17);
        chk("g3_row1", od(1), 3);
        chk("g3_ppctl", bus.o_ppctl, 8'h3C);
        bus.SS_ack = 1'b1;
        tick();
        chk("g3_ack_rdy", bus.SS_rdy, 0);
        bus.SS_ack = 1'b0;

        // saturation, then wrap with ack in the same cycle
        drv(1, 1, 1, 1, 0, 8'h01, 32700, 100, -32768, -1, 0, 0);
        tick();
        chk("sat_pos", od(0), 32767);
        chk("sat_neg", od(1), -32768);
        bus.SS_ack = 1'b1;
        drv(1, 1, 1, 0, 0, 8'h02, 32700, 100, -32768, -1, 0, 0);
        chk("wrap_ms_ack", bus.MS_ack, 1);
        tick();
        chk("wrap_rdy", bus.SS_rdy, 1);
        chk("wrap_pos", od(0), -32736);
        chk("wrap_neg", od(1), 32767);
        chk("wrap_ppctl", bus.o_ppctl, 8'h02);

        // backpressure
        bus.SS_ack = 1'b0;
        drv(1, 1, 0, 0, 0, 8'h44, 7, 1, 0, 0, 0, 0);
        chk("bp_nonlast_ack", bus.MS_ack, 1);
        tick();
        chk("bp_hold1", od(0), -32736);
        drv(1, 0, 1, 0, 0, 8'h55, 0, 2, 0, 0, 0, 0);
        chk("bp_last_stall", bus.MS_ack, 0);
        tick();
        chk("bp_hold2", od(0), -32736);
        chk("bp_hold_rdy", bus.SS_rdy, 1);
        chk("bp_still_stall", bus.MS_ack, 0);
        bus.SS_ack = 1'b1;
        #1;
        chk("bp_release_ack", bus.MS_ack, 1);
        tick();
        chk("bp_rdy", bus.SS_rdy, 1);
        chk("bp_row0", od(0), 10);
        chk("bp_ppctl", bus.o_ppctl, 8'h55);

        // back-to-back single-beat groups
        drv(1, 1, 1, 0, 0, 8'h61, 1, 1, 0, 0, 0, 0);
        tick();
        chk("b2b_a", od(0), 2);
        chk("b2b_a_rdy", bus.SS_rdy, 1);
        drv(1, 1, 1, 0, 1, 8'h62, 2, 1, 0, 0, 0, 0);
        tick();
        chk("b2b_b", od(0), 4);
        drv(1, 1, 1, 0, 3, 8'h63, 3, 1, 0, 0, 0, 0);
        tick();
        chk("b2b_c", od(0), 11);
        chk("b2b_c_rdy", bus.SS_rdy, 1);
        chk("b2b_err", bus.o_err, 0);
        idle();
        tick();
        chk("b2b_drain", bus.SS_rdy, 0);
        bus.SS_ack = 1'b0;

        // first=1 inside a group reloads and flags an error
        drv(1, 1, 0, 0, 0, 8'h70, 500, 1, 0, 0, 0, 0);
        tick();
        chk("rl_err_pre", bus.o_err, 0);
        drv(1, 1, 1, 0, 0, 8'h71, 20, 1, 0, 0, 0, 0);
        tick();
        idle();
        chk("rl_row0", od(0), 21);
        chk("rl_err", bus.o_err, 1);

        // async reset clears error and pending result
        rst_n = 1'b0;
        #1;
        chk("rst2_err", bus.o_err, 0);
        chk("rst2_rdy", bus.SS_rdy, 0);
        tick();
        rst_n = 1'b1;

        // first=0 in IDLE accumulates from zero
        drv(1, 0, 1, 0, 0, 8'h80, 1000, 4, 0, 0, 0, 0);
        tick();
        idle();
        chk("pe_err", bus.o_err, 1);
        chk("pe_row0", od(0), 4);
        chk("pe_rdy", bus.SS_rdy, 1);

        // reset mid-group with a pending result
        drv(1, 1, 0, 0, 0, 8'h90, 900, 9, 0, 0, 0, 0);
        chk("mg_ack", bus.MS_ack, 1);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        chk("mg_rdy", bus.SS_rdy, 0);
        chk("mg_err", bus.o_err, 0);
        chk("mg_row0", od(0), 0);
        tick();
        rst_n = 1'b1;
        drv(1, 1, 1, 0, 2, 8'hA0, 100, 5, 0, 0, 0, 0);
        tick();
        idle();
        chk("post_row0", od(0), 120);
        chk("post_rdy", bus.SS_rdy, 1);
        chk("post_err", bus.o_err, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
